// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS encodings, arbiter state type and a
// one-hot to index helper used by the arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ARB_PARK = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_LOCK = 2'd2
    } arb_state_t;

    localparam int unsigned ARB_PORTS = 4;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational 4-way round-robin picker: first set request bit found when
// searching upward (with wrap) from the start index.
module ahb_rr_pick
    import ahb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk offsets high to low so the smallest offset from start wins.
    always_comb begin
        valid = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = ARB_PORTS - 1; i >= 0; i--) begin
            cand = start + 2'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Four-master AHB bus arbiter with parking, round-robin handover, idle-owner
// timeout and locked-transfer hold. All state advances only when HREADY=1.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int IDLE_TIMEOUT   = 4
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [3:0] HBUSREQ,
    input  logic [3:0] HLOCK,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic [3:0] HGRANT,
    output logic [1:0] HMASTER,
    output logic       HMASTLOCK
);

    if (NUM_MASTERS != 4) begin : g_bad_cfg
        $error("ahb_arbiter supports only NUM_MASTERS = 4");
    end

    localparam logic [3:0] DEFAULT_GRANT = 4'(4'b0001 << DEFAULT_MASTER);
    localparam logic [1:0] DEFAULT_IDX   = 2'(DEFAULT_MASTER);
    localparam logic [2:0] TIMEOUT_LAST  = 3'(IDLE_TIMEOUT - 1);

    arb_state_t state, state_next;
    logic [3:0] grant_next;
    logic [1:0] last, last_next;
    logic [2:0] idle_cnt, idle_next;
    logic [3:0] owner_mask;
    logic [3:0] pick_req;
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] grant_idx;
    logic       idle_inc;
    logic       timeout;

    // The last owner is the current owner while in OWN or LOCK.
    assign owner_mask = 4'(4'b0001 << last);
    assign pick_req   = (state == ARB_OWN) ? (HBUSREQ & ~owner_mask) : HBUSREQ;
    assign grant_idx  = onehot_to_idx(HGRANT);
    assign idle_inc   = (state == ARB_OWN) && (HTRANS == HTRANS_IDLE) &&
                        (|(HBUSREQ & ~owner_mask));
    assign timeout    = idle_inc && (idle_cnt == TIMEOUT_LAST);

    ahb_rr_pick u_pick (
        .req   (pick_req),
        .start (last + 2'd1),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next = state;
        grant_next = HGRANT;
        last_next  = last;
        idle_next  = '0;
        case (state)
            ARB_PARK: begin
                grant_next = DEFAULT_GRANT;
                if (pick_valid) begin
                    grant_next = 4'(4'b0001 << pick_idx);
                    last_next  = pick_idx;
                    state_next = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if ((HTRANS == HTRANS_NONSEQ) && HLOCK[last]) begin
                    state_next = ARB_LOCK;
                end else if (!HBUSREQ[last] || timeout) begin
                    if (pick_valid) begin
                        grant_next = 4'(4'b0001 << pick_idx);
                        last_next  = pick_idx;
                    end else begin
                        grant_next = DEFAULT_GRANT;
                        state_next = ARB_PARK;
                    end
                end else if (idle_inc) begin
                    idle_next = idle_cnt + 3'd1;
                end
            end
            ARB_LOCK: begin
                // Re-arbitration, if the owner also let go, happens once back in OWN.
                if (!HLOCK[last]) state_next = ARB_OWN;
            end
            default: begin
                state_next = ARB_PARK;
                grant_next = DEFAULT_GRANT;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ARB_PARK;
            HGRANT    <= DEFAULT_GRANT;
            HMASTER   <= DEFAULT_IDX;
            HMASTLOCK <= 1'b0;
            idle_cnt  <= '0;
            last      <= 2'd3;
        end else if (HREADY) begin
            state     <= state_next;
            HGRANT    <= grant_next;
            HMASTER   <= grant_idx;
            HMASTLOCK <= HLOCK[grant_idx];
            idle_cnt  <= idle_next;
            last      <= last_next;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: expected grant/master/lock pushed to a
// scoreboard with each stimulus step and popped after the clock edge.
module tb_ahb_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] master;
        logic       mlock;
    } exp_t;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    exp_t sb[$];
    int   n_checks;
    int   n_passed;

    ahb_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0),
        .IDLE_TIMEOUT   (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input logic [3:0] g, input logic [1:0] m, input logic l);
        exp_t e;
        e.grant  = g;
        e.master = m;
        e.mlock  = l;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        assert (HGRANT === e.grant) n_passed++;
        else $error("FAIL %s grant: got %b expected %b", tag, HGRANT, e.grant);
        n_checks++;
        assert (HMASTER === e.master) n_passed++;
        else $error("FAIL %s master: got %0d expected %0d", tag, HMASTER, e.master);
        n_checks++;
        assert (HMASTLOCK === e.mlock) n_passed++;
        else $error("FAIL %s mastlock: got %b expected %b", tag, HMASTLOCK, e.mlock);
        n_checks++;
        assert ($onehot(HGRANT)) n_passed++;
        else $error("FAIL %s onehot: got %b expected one bit set", tag, HGRANT);
    endtask

    task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lck,
                        input logic [1:0] trn, input logic rdy,
                        input logic [3:0] g, input logic [1:0] m, input logic l);
        HBUSREQ = req;
        HLOCK   = lck;
        HTRANS  = trn;
        HREADY  = rdy;
        expect_out(g, m, l);
        @(posedge HCLK);
        #1;
        compare(tag);
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        HRESETn  = 1'b0;
        HBUSREQ  = 4'b0000;
        HLOCK    = 4'b0000;
        HTRANS   = T_IDLE;
        HREADY   = 1'b1;

        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        expect_out(4'b0001, 2'd0, 1'b0);
        compare("reset_hold");
        HRESETn = 1'b1;

        // Nobody requests: parked on master 0.
        for (int i = 0; i < 10; i++)
            step("park_idle", 4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Masters 1 and 3 request; 1 wins first, then 3, then back to park.
        step("rr_first",   4'b1010, 4'b0000, T_NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0);
        step("rr_hold1",   4'b1010, 4'b0000, T_NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b0);
        step("rr_to3",     4'b1000, 4'b0000, T_NONSEQ, 1'b1, 4'b1000, 2'd1, 1'b0);
        step("rr_hold3",   4'b1000, 4'b0000, T_NONSEQ, 1'b1, 4'b1000, 2'd3, 1'b0);
        step("rr_park",    4'b0000, 4'b0000, T_NONSEQ, 1'b1, 4'b0001, 2'd3, 1'b0);
        step("rr_parked",  4'b0000, 4'b0000, T_NONSEQ, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Master 2 owns but stays idle while master 0 waits: timeout after 4 cycles.
        step("to_grant2",  4'b0100, 4'b0000, T_NONSEQ, 1'b1, 4'b0100, 2'd0, 1'b0);
        step("to_idle1",   4'b0101, 4'b0000, T_IDLE,   1'b1, 4'b0100, 2'd2, 1'b0);
        step("to_idle2",   4'b0101, 4'b0000, T_IDLE,   1'b1, 4'b0100, 2'd2, 1'b0);
        step("to_idle3",   4'b0101, 4'b0000, T_IDLE,   1'b1, 4'b0100, 2'd2, 1'b0);
        step("to_idle4",   4'b0101, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd2, 1'b0);
        step("to_release", 4'b0000, 4'b0000, T_NONSEQ, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Master 1 locks while master 0 requests; idle cycles must not time out.
        step("lk_grant1",  4'b0010, 4'b0000, T_NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0);
        step("lk_enter",   4'b0011, 4'b0010, T_NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++)
            step("lk_hold", 4'b0011, 4'b0010, T_IDLE, 1'b1, 4'b0010, 2'd1, 1'b1);
        step("lk_exit",    4'b0001, 4'b0000, T_IDLE,   1'b1, 4'b0010, 2'd1, 1'b0);
        step("lk_rearb",   4'b0001, 4'b0000, T_IDLE,   1'b1, 4'b0001, 2'd1, 1'b0);
        step("lk_own0",    4'b0001, 4'b0000, T_NONSEQ, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Handover from 0 to 2 stalled by HREADY=0.
        for (int i = 0; i < 5; i++)
            step("stall", 4'b0100, 4'b0000, T_NONSEQ, 1'b0, 4'b0001, 2'd0, 1'b0);
        step("stall_done", 4'b0100, 4'b0000, T_NONSEQ, 1'b1, 4'b0100, 2'd0, 1'b0);

        // Reset asserted while master 2 holds a lock.
        step("rl_enter",   4'b0100, 4'b0100, T_NONSEQ, 1'b1, 4'b0100, 2'd2, 1'b1);
        step("rl_hold",    4'b0100, 4'b0100, T_NONSEQ, 1'b1, 4'b0100, 2'd2, 1'b1);
        HRESETn = 1'b0;
        #1;
        expect_out(4'b0001, 2'd0, 1'b0);
        compare("rl_async");
        step("rl_inreset", 4'b0100, 4'b0100, T_NONSEQ, 1'b1, 4'b0001, 2'd0, 1'b0);
        HRESETn = 1'b1;
        // Last owner restarts at 3, so master 1 beats master 3.
        step("rl_first",   4'b1010, 4'b0000, T_NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: HCLK and HRESETn.
REQ-002 SHALL have parameter NUM_MASTERS, default 4, meaning the number of bus masters; only the value 4 is supported.
REQ-003 SHALL have parameter DEFAULT_MASTER, default 0, meaning the master parked on the bus when no master requests it.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 4, meaning the number of consecutive idle owner cycles that forces re-arbitration.
REQ-005 Port: HCLK  in  1  AHB clock.
REQ-006 Port: HRESETn  in  1  asynchronous reset, active-low.
REQ-007 Port: HBUSREQ  in  4  bus request, one bit per master.
REQ-008 Port: HLOCK  in  4  locked-transfer request, one bit per master.
REQ-009 Port: HTRANS  in  2  transfer type of the muxed address phase (0 IDLE, 2 NONSEQ).
REQ-010 Port: HREADY  in  1  previous transfer complete.
REQ-011 Port: HGRANT  out  4  one-hot grant.
REQ-012 Port: HMASTER  out  2  index of the master that owns the address phase.
REQ-013 Port: HMASTLOCK  out  1  the current address phase is locked.

Function
REQ-014 HGRANT SHALL be exactly one-hot in every cycle after reset.
REQ-015 HGRANT, HMASTER, HMASTLOCK, the state and the counters SHALL update only on HCLK edges where HREADY=1; HREADY=0 freezes all of them.
REQ-016 HMASTER SHALL take the index of the HGRANT bit on each HREADY=1 edge, so HMASTER lags HGRANT by one accepted cycle.
REQ-017 HMASTLOCK SHALL be loaded with HLOCK[HMASTER-next] on each HREADY=1 edge.
REQ-018 The FSM SHALL have three states: PARK, OWN and LOCK.
REQ-019 PARK: grant DEFAULT_MASTER; if any HBUSREQ bit is set, grant the round-robin winner and go to OWN.
REQ-020 Round-robin SHALL search upward from (last owner + 1) mod 4 and take the first requester; last owner resets to 3, so master 0 has first priority.
REQ-021 OWN: the owner keeps the grant while HBUSREQ[owner]=1 and no timeout has occurred.
REQ-022 OWN, owner drops HBUSREQ: grant the round-robin winner among the other requesters; if there are none, go to PARK.
REQ-023 OWN, HTRANS=NONSEQ with HLOCK[owner]=1: go to LOCK with no grant change.
REQ-024 Idle counter (3 bits) SHALL increment when state is OWN, HTRANS=IDLE and another master is requesting; otherwise it clears.
REQ-025 When the idle counter reaches IDLE_TIMEOUT, the arbiter SHALL re-arbitrate excluding the owner and clear the counter.
REQ-026 LOCK: the grant SHALL be held regardless of other requests, and the idle counter SHALL be held at 0.
REQ-027 LOCK SHALL exit to OWN on the first HREADY=1 cycle with HLOCK[owner]=0.
REQ-028 When the owner's request drops and HLOCK drops in the same cycle, the arbiter SHALL take the LOCK to OWN exit and re-arbitrate in the following cycle.
REQ-029 A request that arrives in the same cycle the owner releases SHALL be a candidate in that cycle's arbitration.
REQ-030 The grant for a new owner SHALL appear on HGRANT one cycle after the deciding edge; there are no combinational paths from inputs to outputs.

Reset
REQ-031 While HRESETn=0, the block SHALL hold HGRANT=4'b0001<<DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0, state=PARK, idle counter=0 and last owner=3.
REQ-032 Reset assertion SHALL take effect immediately, including mid-transfer or in LOCK.
REQ-033 Reset release SHALL be sampled synchronously; the first arbitration happens on the first HCLK edge after release.

Structure
REQ-034 The shared package ahb_pkg SHALL hold the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and the arbiter state enum.
REQ-035 The block SHALL contain one sub-module, ahb_rr_pick: a combinational 4-way round-robin picker with inputs request mask and start index, and outputs valid and index.

Verification
REQ-036 Reset, then HBUSREQ=0 -> HGRANT=0001 and HMASTER=0 held for 10 cycles.
REQ-037 HBUSREQ=1010 from cycle 1 with HREADY=1 -> HGRANT=0010; master 1 releases -> HGRANT=1000 one cycle later; master 3 releases -> PARK with HGRANT=0001.
REQ-038 Master 2 owns the bus with HTRANS=IDLE and HBUSREQ=0101 -> HGRANT moves to 0001 after 4 idle cycles.
REQ-039 Master 1 sends NONSEQ with HLOCK[1]=1 while master 0 requests -> HGRANT stays 0010 and HMASTLOCK=1 until HLOCK[1]=0, then HGRANT=0001.
REQ-040 HREADY=0 for 5 cycles during a handover -> HGRANT and HMASTER frozen, and the handover completes on the first HREADY=1 edge.
REQ-041 HRESETn asserted mid-LOCK -> HGRANT=0001 and HMASTLOCK=0 asynchronously, before the next HCLK edge.
